// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - ALU control codes, divider states and shared helpers for the EX stage
package ex_stage_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_BEQ    = 5'd10,
        ALU_BNE    = 5'd11,
        ALU_BLT    = 5'd12,
        ALU_BGE    = 5'd13,
        ALU_BLTU   = 5'd14,
        ALU_BGEU   = 5'd15,
        ALU_PASSB  = 5'd16,
        ALU_MUL    = 5'd17,
        ALU_MULH   = 5'd18,
        ALU_MULHSU = 5'd19,
        ALU_MULHU  = 5'd20,
        ALU_DIV    = 5'd21,
        ALU_DIVU   = 5'd22,
        ALU_REM    = 5'd23,
        ALU_REMU   = 5'd24
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef enum logic [1:0] {
        DOP_DIV  = 2'd0,
        DOP_DIVU = 2'd1,
        DOP_REM  = 2'd2,
        DOP_REMU = 2'd3
    } div_op_e;

    function automatic logic is_div_code(input logic [4:0] ctrl);
        return (ctrl >= ALU_DIV) && (ctrl <= ALU_REMU);
    endfunction

endpackage

// File: rtl/ex_div.sv
// rtl/ex_div.sv - iterative restoring divider, one quotient bit per cycle with sign fix-up
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  div_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_e      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            neg_quo;
    logic            neg_rem;
    logic            want_rem;

    logic            op_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    assign op_signed = (op == DOP_DIV) || (op == DOP_REM);
    assign a_neg     = op_signed & a[XLEN-1];
    assign b_neg     = op_signed & b[XLEN-1];
    assign a_abs     = a_neg ? ('0 - a) : a;
    assign b_abs     = b_neg ? ('0 - b) : b;
    assign div_zero  = (b == '0);
    assign div_ovf   = op_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

    // Partial remainder shifted left by one with the next dividend bit; a clear
    // borrow bit means the divisor fits and the quotient bit is 1.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    assign busy = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
    assign done = (state == DIV_DONE);

    // Divider FSM: latch magnitudes in IDLE, iterate in BUSY, present result in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DIV_IDLE;
            count    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            want_rem <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        want_rem <= (op == DOP_REM) || (op == DOP_REMU);
                        count    <= '0;
                        if (div_zero) begin
                            // Special results are stored already final, so fix-up is disabled
                            quo_q   <= '1;
                            rem_q   <= a;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= DIV_DONE;
                        end else if (div_ovf) begin
                            quo_q   <= {1'b1, {(XLEN-1){1'b0}}};
                            rem_q   <= '0;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                            state   <= DIV_DONE;
                        end else begin
                            quo_q   <= a_abs;
                            rem_q   <= '0;
                            dvs_q   <= b_abs;
                            neg_quo <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (flush) begin
                        state <= DIV_IDLE;
                        count <= '0;
                    end else begin
                        rem_q <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], ~diff[XLEN]};
                        if (count == CW'(DIV_CYCLES - 1)) begin
                            state <= DIV_DONE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                    count <= '0;
                end
                default: begin
                    state <= DIV_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    // Sign correction: quotient negated when signs differ, remainder follows the dividend
    always_comb begin
        result = '0;
        if (done) begin
            if (want_rem) begin
                result = neg_rem ? ('0 - rem_q) : rem_q;
            end else begin
                result = neg_quo ? ('0 - quo_q) : quo_q;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolve, multiply, divide stall and EX/MEM bubble
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] idex_op_a_i,
    input  logic [XLEN-1:0] idex_op_b_i,
    input  logic [4:0]      idex_reg_waddr_i,
    input  logic            idex_reg_we_i,
    input  logic [4:0]      idex_ALUctrl_i,
    input  logic            idex_btype_flag_i,
    input  logic [XLEN-1:0] idex_btype_jump_pc_i,
    input  logic            idex_mtype_i,
    input  logic            idex_mem_rw_i,
    input  logic            idex_mem_rdtype_i,
    input  logic [1:0]      idex_mem_width_i,
    input  logic [XLEN-1:0] idex_mem_wr_data_i,
    input  logic            idex_csr_we_i,
    input  logic [11:0]     idex_csr_waddr_i,
    input  logic [XLEN-1:0] idex_csr_rdata_i,
    input  logic            fc_flush_ex_i,
    output logic [XLEN-1:0] ex_result_o,
    output logic [4:0]      ex_reg_waddr_o,
    output logic            ex_reg_we_o,
    output logic            ex_jump_flag_o,
    output logic [XLEN-1:0] ex_jump_pc_o,
    output logic            ex_stall_req_o,
    output logic            ex_mtype_o,
    output logic            ex_mem_rw_o,
    output logic [1:0]      ex_mem_width_o,
    output logic [XLEN-1:0] ex_mem_wr_data_o,
    output logic            ex_mem_rdtype_o,
    output logic            ex_csr_we_o,
    output logic [11:0]     ex_csr_waddr_o,
    output logic [XLEN-1:0] ex_csr_rdata_o
);

    localparam int SW = $clog2(XLEN);

    alu_ctrl_e         op;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   alu_res;
    logic              br_cond;
    logic              mul_a_signed;
    logic              mul_b_signed;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] product;
    logic              div_start;
    div_op_e           div_op;
    logic              div_busy;
    logic              div_done;
    logic [XLEN-1:0]   div_result;
    logic              stall;

    assign op    = alu_ctrl_e'(idex_ALUctrl_i);
    assign shamt = idex_op_b_i[SW-1:0];

    // One shared 64-bit multiplier; operand extension picks the signedness of the high half
    assign mul_a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
    assign mul_b_signed = (op == ALU_MULH);
    assign mul_a   = {{XLEN{mul_a_signed & idex_op_a_i[XLEN-1]}}, idex_op_a_i};
    assign mul_b   = {{XLEN{mul_b_signed & idex_op_b_i[XLEN-1]}}, idex_op_b_i};
    assign product = mul_a * mul_b;

    // Single-cycle ALU, branch condition and multiply-half selection
    always_comb begin
        alu_res = '0;
        br_cond = 1'b0;
        case (op)
            ALU_ADD:    alu_res = idex_op_a_i + idex_op_b_i;
            ALU_SUB:    alu_res = idex_op_a_i - idex_op_b_i;
            ALU_SLL:    alu_res = idex_op_a_i << shamt;
            ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(idex_op_a_i) < $signed(idex_op_b_i)};
            ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, idex_op_a_i < idex_op_b_i};
            ALU_XOR:    alu_res = idex_op_a_i ^ idex_op_b_i;
            ALU_SRL:    alu_res = idex_op_a_i >> shamt;
            ALU_SRA:    alu_res = $signed(idex_op_a_i) >>> shamt;
            ALU_OR:     alu_res = idex_op_a_i | idex_op_b_i;
            ALU_AND:    alu_res = idex_op_a_i & idex_op_b_i;
            ALU_BEQ:    br_cond = (idex_op_a_i == idex_op_b_i);
            ALU_BNE:    br_cond = (idex_op_a_i != idex_op_b_i);
            ALU_BLT:    br_cond = ($signed(idex_op_a_i) < $signed(idex_op_b_i));
            ALU_BGE:    br_cond = ($signed(idex_op_a_i) >= $signed(idex_op_b_i));
            ALU_BLTU:   br_cond = (idex_op_a_i < idex_op_b_i);
            ALU_BGEU:   br_cond = (idex_op_a_i >= idex_op_b_i);
            ALU_PASSB:  alu_res = idex_op_b_i;
            ALU_MUL:    alu_res = product[XLEN-1:0];
            ALU_MULH:   alu_res = product[2*XLEN-1:XLEN];
            ALU_MULHSU: alu_res = product[2*XLEN-1:XLEN];
            ALU_MULHU:  alu_res = product[2*XLEN-1:XLEN];
            default:    alu_res = '0;
        endcase
    end

    // Map the divide codes onto the divider's own operation select
    always_comb begin
        div_op = DOP_DIV;
        case (op)
            ALU_DIVU: div_op = DOP_DIVU;
            ALU_REM:  div_op = DOP_REM;
            ALU_REMU: div_op = DOP_REMU;
            default:  div_op = DOP_DIV;
        endcase
    end

    assign div_start = is_div_code(idex_ALUctrl_i);

    ex_div #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (div_start),
        .op     (div_op),
        .a      (idex_op_a_i),
        .b      (idex_op_b_i),
        .flush  (fc_flush_ex_i),
        .busy   (div_busy),
        .done   (div_done),
        .result (div_result)
    );

    // A pending divide turns this slot into a bubble: no write, no redirect, no memory op
    assign stall          = div_busy;
    assign ex_stall_req_o = stall;
    assign ex_result_o    = div_start ? (div_done ? div_result : '0) : alu_res;
    assign ex_reg_we_o    = idex_reg_we_i & ~stall;
    assign ex_reg_waddr_o = stall ? 5'd0 : idex_reg_waddr_i;
    assign ex_jump_flag_o = idex_btype_flag_i & br_cond & ~stall;
    assign ex_jump_pc_o   = ex_jump_flag_o ? idex_btype_jump_pc_i : '0;

    assign ex_mtype_o       = stall ? 1'b0  : idex_mtype_i;
    assign ex_mem_rw_o      = stall ? 1'b0  : idex_mem_rw_i;
    assign ex_mem_width_o   = stall ? 2'b00 : idex_mem_width_i;
    assign ex_mem_wr_data_o = stall ? '0    : idex_mem_wr_data_i;
    assign ex_mem_rdtype_o  = stall ? 1'b0  : idex_mem_rdtype_i;
    assign ex_csr_we_o      = stall ? 1'b0  : idex_csr_we_i;
    assign ex_csr_waddr_o   = stall ? 12'd0 : idex_csr_waddr_i;
    assign ex_csr_rdata_o   = stall ? '0    : idex_csr_rdata_i;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the core0 5-stage pipeline.
- Consumes the registered ID/EX bundle. Performs ALU, branch resolution and single-cycle multiply. Performs 32-bit divide/remainder with an iterative restoring divider.
- Drives the EX/MEM register and the flow controller (fc): a branch-taken redirect, plus a stall request while a divide is in flight.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CYCLES, 32, number of BUSY iterations of the divider; must equal XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- idex_op_a_i  in  32  operand A (rs1 or PC)
- idex_op_b_i  in  32  operand B (rs2 or imm)
- idex_reg_waddr_i  in  5  destination register
- idex_reg_we_i  in  1  register write enable
- idex_ALUctrl_i  in  5  operation code
- idex_btype_flag_i  in  1  conditional-branch instruction
- idex_btype_jump_pc_i  in  32  branch target
- idex_mtype_i, idex_mem_rw_i, idex_mem_rdtype_i  in  1 each  memory controls, passed through
- idex_mem_width_i  in  2  passed through
- idex_mem_wr_data_i  in  32  passed through
- idex_csr_we_i  in  1  passed through
- idex_csr_waddr_i  in  12  passed through
- idex_csr_rdata_i  in  32  passed through
- fc_flush_ex_i  in  1  abort the in-flight divide
- ex_result_o  out  32  ALU/mul/div result (memory address for mtype)
- ex_reg_waddr_o  out  5
- ex_reg_we_o  out  1  gated write enable
- ex_jump_flag_o  out  1  branch taken
- ex_jump_pc_o  out  32  redirect target
- ex_stall_req_o  out  1  to fc: hold PC/IFID/IDEX, bubble EX/MEM
- ex_mtype_o, ex_mem_rw_o, ex_mem_width_o, ex_mem_wr_data_o, ex_mem_rdtype_o, ex_csr_we_o, ex_csr_waddr_o, ex_csr_rdata_o  out  pass-through of the matching inputs

Behaviour:
- ALUctrl encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - BEQ=10, BNE=11, BLT=12, BGE=13, BLTU=14, BGEU=15
  - PASSB=16
  - MUL=17, MULH=18, MULHSU=19, MULHU=20
  - DIV=21, DIVU=22, REM=23, REMU=24
  - Codes 25-31 give result 0.
- Non-divide ops are combinational with 0-cycle latency to the EX/MEM register.
  - Shifts use op_b[4:0]; all arithmetic wraps modulo 2^32.
  - MUL* use a 64-bit product and select the low or high half.
- Branch codes: result = 0. ex_jump_flag_o = idex_btype_flag_i AND condition true. ex_jump_pc_o = idex_btype_jump_pc_i, else 0.
- Divider FSM states: IDLE, BUSY, DONE. It resets to IDLE with count=0 and all datapath regs 0.
  - IDLE with a div code: ex_stall_req_o=1 combinationally. Latch |a|, |b| and the sign flags.
    - Divisor == 0 or signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go to DONE directly.
    - Otherwise go to BUSY with count=0.
  - BUSY: one quotient bit per cycle. After DIV_CYCLES iterations (count=31), go to DONE. ex_stall_req_o=1.
  - DONE: ex_stall_req_o=0. Apply sign correction: quotient negative if signs differ; remainder takes the dividend's sign. Result is valid this cycle. Return to IDLE.
  - Latency: normal divide = 34 EX cycles (1+32+1); special-case divide = 2 cycles.
- Divide special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = a.
  - Signed overflow: quotient 0x80000000, remainder 0.
- ex_reg_we_o = idex_reg_we_i AND NOT ex_stall_req_o, so no write or forward occurs for a pending divide.
- ex_jump_flag_o is never asserted while ex_stall_req_o=1.
- Pass-through outputs are also zeroed while ex_stall_req_o=1, which makes the bubble.
- Reset mid-divide: asynchronous return to IDLE; stall_req drops immediately.
- fc_flush_ex_i=1 in BUSY or DONE: next state IDLE and count cleared. The flushed instruction does not restart, because fc flushes IDEX in the same cycle.
- Back-to-back divides: DONE → IDLE, then the new IDEX content starts a fresh divide.
- Operands are sampled only in IDLE. IDEX is held by fc during BUSY, so inputs are stable anyway.

Decomposition:
- The ALUctrl codes and the FSM state encodings go in define.v.
- The iterative divider is the natural sub-module: ex_div. It owns the FSM, the counter and sign fix-up, with ports start/op/a/b/flush → busy/done/result.
- ALU, branch compare and multiply stay inline in ex_stage.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000, we=1, stall_req=0 in the same cycle.
- BLT with flag=1, a=0xFFFFFFFF, b=1, target 0x100 → jump_flag=1, jump_pc=0x100. BLTU with the same operands → jump_flag=0.
- DIV a=-7, b=2 → stall_req high for 33 cycles; DONE cycle result=0xFFFFFFFD, we=1. REM with the same operands → 0xFFFFFFFF.
- DIVU a=5, b=0 → 2-cycle latency, result 0xFFFFFFFF. REM a=0x80000000, b=-1 → result 0.
- fc_flush_ex_i pulsed at BUSY count=10 → next cycle IDLE, stall_req=0, no reg write.
- rst_n asserted at BUSY count=20 → all outputs 0 and stall_req=0 asynchronously. After release, DIVU 100/7 completes with result 14.
